frame_step_ctrl: RTL and testbench

Frame-rate sequencer that drives the physics engine from the other side of its step handshake. Once per video frame it samples both players' buttons and computes the `p1_cover`/`p2_cover` ball-vs-player overlap flags from the last committed positions. It then pulses `en` to the physics engine, waits for `valid`, and commits the new positions and score into display-stable registers for the renderer.

---
 rtl/fstep_pkg.sv | 50 +++++
 rtl/fstep_cover.sv | 76 +++++++
 rtl/frame_step_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_frame_step_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fstep_pkg.sv
// rtl/fstep_pkg.sv - shared constants, types and helpers for the frame step sequencer
//
// Purpose: coordinate width, ball and player geometry, reset positions,
// sequencer state encodings and the clamp/magnitude helpers used by the
// cover test.
package fstep_pkg;

  localparam int COORD_W     = 10;
  localparam int BALL_SIZE   = 40;
  localparam int BALL_R      = BALL_SIZE / 2;
  localparam int BALL_R2     = BALL_R * BALL_R;
  localparam int PLAYER_SIZE = 64;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  localparam pos_t P1_INIT   = '{x: 10'd50,  y: 10'd176};
  localparam pos_t P2_INIT   = '{x: 10'd260, y: 10'd176};
  localparam pos_t BALL_INIT = '{x: 10'd260, y: 10'd120};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LATCH  = 3'd1;
  localparam logic [2:0] S_CLAMP  = 3'd2;
  localparam logic [2:0] S_SQX    = 3'd3;
  localparam logic [2:0] S_SQY    = 3'd4;
  localparam logic [2:0] S_ISSUE  = 3'd5;
  localparam logic [2:0] S_WAIT   = 3'd6;
  localparam logic [2:0] S_COMMIT = 3'd7;

  // Nearest point of the player box [lo, lo+PLAYER_SIZE-1] to v.
  function automatic logic [11:0] clamp_box(input logic [11:0] v, input logic [11:0] lo);
    logic [11:0] hi;
    hi = lo + 12'(PLAYER_SIZE - 1);
    if (v < lo) return lo;
    else if (v > hi) return hi;
    else return v;
  endfunction

  // Magnitude of a signed 12-bit difference; the clamp keeps it below 2048.
  function automatic logic [10:0] mag11(input logic [11:0] d);
    logic [11:0] n;
    n = d[11] ? (12'd0 - d) : d;
    return n[10:0];
  endfunction

endpackage

// File: rtl/fstep_cover.sv
// rtl/fstep_cover.sv - ball-vs-player overlap test with one shared squarer
//
// Purpose: on start_i, clamps the ball centre into the selected player box
// and registers |dx|,|dy|; the next cycle squares dx, the third squares dy,
// adds it and raises done_o with cover_o = (dx^2 + dy^2 <= radius^2).
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           one-cycle start (sequencer CLAMP state)
//   sel_i             0 = player 1 box, 1 = player 2 box
//   ball_i, p1_i, p2_i positions used for the test
//   done_o, cover_o   result valid in the third cycle
module fstep_cover
  import fstep_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic sel_i,
  input  pos_t ball_i,
  input  pos_t p1_i,
  input  pos_t p2_i,
  output logic done_o,
  output logic cover_o
);

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_SQX  = 2'd1;
  localparam logic [1:0] PH_SQY  = 2'd2;

  logic [1:0]  phase_q;
  logic [10:0] ax_q, ay_q;
  logic [21:0] acc_q;
  pos_t        pl;
  logic [11:0] cx, cy, px, py;
  logic [10:0] sq_op;
  logic [21:0] sq, sum;

  always_comb begin
    pl = sel_i ? p2_i : p1_i;
    cx = {2'b00, ball_i.x} + 12'(BALL_R);
    cy = {2'b00, ball_i.y} + 12'(BALL_R);
    px = clamp_box(cx, {2'b00, pl.x});
    py = clamp_box(cy, {2'b00, pl.y});
  end

  // Single squarer: dx in SQX, dy in SQY.
  assign sq_op = (phase_q == PH_SQX) ? ax_q : ay_q;
  assign sq    = {11'd0, sq_op} * {11'd0, sq_op};
  assign sum   = acc_q + sq;

  assign done_o  = (phase_q == PH_SQY);
  assign cover_o = (sum <= 22'(BALL_R2));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= PH_IDLE;
      ax_q    <= '0;
      ay_q    <= '0;
      acc_q   <= '0;
    end else begin
      case (phase_q)
        PH_IDLE: if (start_i) begin
          ax_q    <= mag11(cx - px);
          ay_q    <= mag11(cy - py);
          phase_q <= PH_SQX;
        end
        PH_SQX: begin
          acc_q   <= sq;
          phase_q <= PH_SQY;
        end
        default: phase_q <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/frame_step_ctrl.sv
// rtl/frame_step_ctrl.sv - per-frame sequencer driving the physics step handshake
//
// Purpose: each frame_tick latches buttons, computes both cover flags from
// the displayed positions, pulses en_o, waits for phy_valid_i and commits
// positions and saturating scores into display registers.
// Optional watchdog: define FSTEP_WDOG_EN to abort WAIT after TIMEOUT cycles.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   frame_tick_i                 one pulse per video frame
//   p1_btn_i, p2_btn_i           {smash, jump, right, left}
//   phy_*_i                      physics positions, valid, game_over, winner
//   en_o                         physics step start (one cycle)
//   p*_op_*_o, p*_is_smash_o     latched ops, stable across the step
//   p1_cover_o, p2_cover_o       ball overlaps player box
//   disp_*_o                     committed positions
//   score_p1_o, score_p2_o       saturating scores; match_over_o sticky
//   frame_done_o                 one-cycle pulse in COMMIT
//   overrun_cnt_o                saturating count of dropped ticks
//   step_err_o                   sticky watchdog abort
module frame_step_ctrl
  import fstep_pkg::*;
#(
  parameter int TIMEOUT   = 64,
  parameter int MAX_SCORE = 15
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         frame_tick_i,
  input  logic [3:0]   p1_btn_i,
  input  logic [3:0]   p2_btn_i,
  input  logic [9:0]   phy_p1_x_i,
  input  logic [9:0]   phy_p1_y_i,
  input  logic [9:0]   phy_p2_x_i,
  input  logic [9:0]   phy_p2_y_i,
  input  logic [9:0]   phy_ball_x_i,
  input  logic [9:0]   phy_ball_y_i,
  input  logic         phy_valid_i,
  input  logic         phy_game_over_i,
  input  logic [1:0]   phy_winner_i,
  output logic         en_o,
  output logic         p1_op_move_left_o,
  output logic         p1_op_move_right_o,
  output logic         p1_op_jump_o,
  output logic         p1_is_smash_o,
  output logic         p2_op_move_left_o,
  output logic         p2_op_move_right_o,
  output logic         p2_op_jump_o,
  output logic         p2_is_smash_o,
  output logic         p1_cover_o,
  output logic         p2_cover_o,
  output logic [9:0]   disp_p1_x_o,
  output logic [9:0]   disp_p1_y_o,
  output logic [9:0]   disp_p2_x_o,
  output logic [9:0]   disp_p2_y_o,
  output logic [9:0]   disp_ball_x_o,
  output logic [9:0]   disp_ball_y_o,
  output logic [3:0]   score_p1_o,
  output logic [3:0]   score_p2_o,
  output logic         match_over_o,
  output logic         frame_done_o,
  output logic [7:0]   overrun_cnt_o,
  output logic         step_err_o
);

  localparam logic [3:0] MAX4 = 4'(MAX_SCORE);

  logic [2:0] state_q, state_d;
  logic       sel_q;
  logic [3:0] p1_ops_q, p2_ops_q;
  logic       p1_cover_q, p2_cover_q;
  pos_t       p1_q, p2_q, ball_q;
  logic [3:0] score1_q, score2_q, score1_d, score2_d;
  logic       go_prev_q, match_over_q;
  logic [7:0] overrun_q;
  logic       cov_done, cov_hit;
  logic       wdog_expire;

`ifdef FSTEP_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wdog_q;
  logic            step_err_q;
  assign wdog_expire = (wdog_q == WD_LAST);
  assign step_err_o  = step_err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign wdog_expire    = 1'b0;
  assign step_err_o     = 1'b0;
`endif

  // disp registers only move in COMMIT, so they are stable cover inputs
  // for the whole LATCH..SQY window.
  fstep_cover u_cover (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (state_q == S_CLAMP),
    .sel_i   (sel_q),
    .ball_i  (ball_q),
    .p1_i    (p1_q),
    .p2_i    (p2_q),
    .done_o  (cov_done),
    .cover_o (cov_hit)
  );

  // Score only on the rising edge of game_over across commits.
  always_comb begin
    score1_d = score1_q;
    score2_d = score2_q;
    if (phy_game_over_i && !go_prev_q) begin
      if (phy_winner_i == 2'd1 && score1_q != MAX4) score1_d = score1_q + 4'd1;
      if (phy_winner_i == 2'd2 && score2_q != MAX4) score2_d = score2_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (frame_tick_i && !match_over_q) state_d = S_LATCH;
      S_LATCH:  state_d = S_CLAMP;
      S_CLAMP:  state_d = S_SQX;
      S_SQX:    state_d = S_SQY;
      S_SQY:    if (cov_done) state_d = sel_q ? S_ISSUE : S_CLAMP;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT: begin
        if (phy_valid_i) state_d = S_COMMIT;
        else if (wdog_expire) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      p1_ops_q     <= '0;
      p2_ops_q     <= '0;
      p1_cover_q   <= 1'b0;
      p2_cover_q   <= 1'b0;
      p1_q         <= P1_INIT;
      p2_q         <= P2_INIT;
      ball_q       <= BALL_INIT;
      score1_q     <= '0;
      score2_q     <= '0;
      go_prev_q    <= 1'b0;
      match_over_q <= 1'b0;
      overrun_q    <= '0;
`ifdef FSTEP_WDOG_EN
      wdog_q       <= '0;
      step_err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (frame_tick_i && state_q != S_IDLE && overrun_q != 8'hFF)
        overrun_q <= overrun_q + 8'd1;
      case (state_q)
        S_LATCH: begin
          p1_ops_q <= p1_btn_i;
          p2_ops_q <= p2_btn_i;
          sel_q    <= 1'b0;
        end
        S_SQY: if (cov_done) begin
          if (sel_q) p2_cover_q <= cov_hit;
          else begin
            p1_cover_q <= cov_hit;
            sel_q      <= 1'b1;
          end
        end
`ifdef FSTEP_WDOG_EN
        S_ISSUE: wdog_q <= '0;
        S_WAIT: begin
          if (!phy_valid_i && wdog_expire) step_err_q <= 1'b1;
          else wdog_q <= wdog_q + WD_W'(1);
        end
`endif
        S_COMMIT: begin
          p1_q         <= '{x: phy_p1_x_i, y: phy_p1_y_i};
          p2_q         <= '{x: phy_p2_x_i, y: phy_p2_y_i};
          ball_q       <= '{x: phy_ball_x_i, y: phy_ball_y_i};
          score1_q     <= score1_d;
          score2_q     <= score2_d;
          go_prev_q    <= phy_game_over_i;
          match_over_q <= match_over_q | (score1_d == MAX4) | (score2_d == MAX4);
        end
        default: ;
      endcase
    end
  end

  assign en_o               = (state_q == S_ISSUE);
  assign frame_done_o       = (state_q == S_COMMIT);
  assign p1_op_move_left_o  = p1_ops_q[0];
  assign p1_op_move_right_o = p1_ops_q[1];
  assign p1_op_jump_o       = p1_ops_q[2];
  assign p1_is_smash_o      = p1_ops_q[3];
  assign p2_op_move_left_o  = p2_ops_q[0];
  assign p2_op_move_right_o = p2_ops_q[1];
  assign p2_op_jump_o       = p2_ops_q[2];
  assign p2_is_smash_o      = p2_ops_q[3];
  assign p1_cover_o         = p1_cover_q;
  assign p2_cover_o         = p2_cover_q;
  assign disp_p1_x_o        = p1_q.x;
  assign disp_p1_y_o        = p1_q.y;
  assign disp_p2_x_o        = p2_q.x;
  assign disp_p2_y_o        = p2_q.y;
  assign disp_ball_x_o      = ball_q.x;
  assign disp_ball_y_o      = ball_q.y;
  assign score_p1_o         = score1_q;
  assign score_p2_o         = score2_q;
  assign match_over_o       = match_over_q;
  assign overrun_cnt_o      = overrun_q;

endmodule

// File: tb/tb_frame_step_ctrl.sv
// tb/tb_frame_step_ctrl.sv - self-checking bench for frame_step_ctrl
module tb_frame_step_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [3:0] p1_btn = '0, p2_btn = '0;
  logic [9:0] phy_p1_x = '0, phy_p1_y = '0, phy_p2_x = '0, phy_p2_y = '0;
  logic [9:0] phy_ball_x = '0, phy_ball_y = '0;
  logic       phy_valid = 1'b0, phy_game_over = 1'b0;
  logic [1:0] phy_winner = '0;

  logic       en, p1_l, p1_r, p1_j, p1_s, p2_l, p2_r, p2_j, p2_s;
  logic       p1_cover, p2_cover, match_over, frame_done, step_err;
  logic [9:0] d_p1x, d_p1y, d_p2x, d_p2y, d_bx, d_by;
  logic [3:0] score_p1, score_p2;
  logic [7:0] overrun_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_step_ctrl dut (
    .clk_i(clk), .rst_i(rst), .frame_tick_i(frame_tick),
    .p1_btn_i(p1_btn), .p2_btn_i(p2_btn),
    .phy_p1_x_i(phy_p1_x), .phy_p1_y_i(phy_p1_y),
    .phy_p2_x_i(phy_p2_x), .phy_p2_y_i(phy_p2_y),
    .phy_ball_x_i(phy_ball_x), .phy_ball_y_i(phy_ball_y),
    .phy_valid_i(phy_valid), .phy_game_over_i(phy_game_over), .phy_winner_i(phy_winner),
    .en_o(en),
    .p1_op_move_left_o(p1_l), .p1_op_move_right_o(p1_r), .p1_op_jump_o(p1_j), .p1_is_smash_o(p1_s),
    .p2_op_move_left_o(p2_l), .p2_op_move_right_o(p2_r), .p2_op_jump_o(p2_j), .p2_is_smash_o(p2_s),
    .p1_cover_o(p1_cover), .p2_cover_o(p2_cover),
    .disp_p1_x_o(d_p1x), .disp_p1_y_o(d_p1y), .disp_p2_x_o(d_p2x), .disp_p2_y_o(d_p2y),
    .disp_ball_x_o(d_bx), .disp_ball_y_o(d_by),
    .score_p1_o(score_p1), .score_p2_o(score_p2), .match_over_o(match_over),
    .frame_done_o(frame_done), .overrun_cnt_o(overrun_cnt), .step_err_o(step_err)
  );

  typedef struct {
    logic [9:0] p1x, p1y, p2x, p2y, bx, by;
    logic [3:0] b1, b2;
    logic [7:0] exp_ops;
    logic       exp_c1, exp_c2;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ops();
    return {p1_s, p1_j, p1_r, p1_l, p2_s, p2_j, p2_r, p2_l};
  endfunction

  function automatic logic [59:0] disp();
    return {d_p1x, d_p1y, d_p2x, d_p2y, d_bx, d_by};
  endfunction

  // One frame with the bench acting as physics engine; latencies are in
  // clock edges after the edge that samples the tick (-1 = not seen).
  task automatic do_frame(input int vdelay, input int bound, input bit tick_wait,
                          input bit tick_valid, input bit flip_btn,
                          output int en_lat, output int done_lat);
    en_lat = -1;
    done_lat = -1;
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    for (int k = 1; k <= bound && done_lat < 0; k++) begin
      @(posedge clk);
      #1;
      phy_valid = 1'b0;
      frame_tick = 1'b0;
      if (en && en_lat < 0) en_lat = k;
      if (frame_done) done_lat = k;
      if (en_lat > 0 && k == en_lat + 2) begin
        if (tick_wait) frame_tick = 1'b1;
        if (flip_btn) p1_btn = ~p1_btn;
      end
      if (en_lat > 0 && k == en_lat + vdelay) begin
        phy_valid = 1'b1;
        if (tick_valid) frame_tick = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    phy_valid = 1'b0;
    frame_tick = 1'b0;
  endtask

  initial begin
    int el, dl, j;
    bit seen;

    vt[0] = '{50, 176, 260, 176,  50,  96, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0};
    vt[1] = '{50, 176, 260, 176,  50, 100, 4'b0001, 4'b0010, 8'h12, 1'b0, 1'b0};
    vt[2] = '{50, 176, 260, 176,  44, 156, 4'b0100, 4'b1000, 8'h48, 1'b1, 1'b0};
    vt[3] = '{50, 176, 260, 176,  93, 136, 4'b1000, 4'b0001, 8'h81, 1'b1, 1'b0};
    vt[4] = '{50, 176, 260, 176,  93, 135, 4'b0010, 4'b0100, 8'h24, 1'b0, 1'b0};
    vt[5] = '{50, 176, 260, 176, 240, 156, 4'b1111, 4'b0000, 8'hF0, 1'b0, 1'b1};
    vt[6] = '{50, 176, 260, 176, 315, 140, 4'b0000, 4'b1111, 8'h0F, 1'b0, 1'b1};
    vt[7] = '{50, 176, 260, 176, 315, 139, 4'b0101, 4'b1010, 8'h5A, 1'b0, 1'b0};
    vt[8] = '{500, 20, 260, 176, 480,   0, 4'b1010, 4'b0101, 8'hA5, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_en", en, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_ops", ops(), 8'h00);
    chk("rst_cover", {p1_cover, p2_cover}, 2'b00);
    chk("rst_scores", {score_p1, score_p2, match_over}, 9'd0);
    chk("rst_overrun", overrun_cnt, 8'd0);
    chk("rst_step_err", step_err, 1'b0);
    chk("rst_disp", disp(), {10'd50, 10'd176, 10'd260, 10'd176, 10'd260, 10'd120});

    // Frame i commits vt[i]; frame i+1 reports the cover of vt[i].
    for (int i = 0; i <= 9; i++) begin
      j = (i < 9) ? i : 8;
      {phy_p1_x, phy_p1_y, phy_p2_x, phy_p2_y} = {vt[j].p1x, vt[j].p1y, vt[j].p2x, vt[j].p2y};
      {phy_ball_x, phy_ball_y} = {vt[j].bx, vt[j].by};
      {p1_btn, p2_btn} = {vt[j].b1, vt[j].b2};
      do_frame(5, 40, 1'b0, 1'b0, 1'b0, el, dl);
      chk($sformatf("en_lat[%0d]", i), el, 7);
      chk($sformatf("done_lat[%0d]", i), dl, 13);
      if (i == 0) chk("cover_init", {p1_cover, p2_cover}, 2'b00);
      else chk($sformatf("cover[%0d]", i - 1), {p1_cover, p2_cover}, {vt[i-1].exp_c1, vt[i-1].exp_c2});
      if (i < 9) begin
        chk($sformatf("ops[%0d]", i), ops(), vt[i].exp_ops);
        chk($sformatf("disp[%0d]", i), disp(),
            {vt[i].p1x, vt[i].p1y, vt[i].p2x, vt[i].p2y, vt[i].bx, vt[i].by});
      end
    end

    // Buttons change mid-WAIT: ops keep the LATCH value.
    p1_btn = 4'b0011;
    do_frame(5, 40, 1'b0, 1'b0, 1'b1, el, dl);
    chk("btn_flip_ops", ops(), 8'h35);
    chk("btn_flip_done", dl, 13);

    // Tick during WAIT, then tick coinciding with valid.
    do_frame(5, 40, 1'b1, 1'b0, 1'b0, el, dl);
    chk("overrun_wait", overrun_cnt, 8'd1);
    chk("overrun_wait_done", dl, 13);
    do_frame(5, 40, 1'b0, 1'b1, 1'b0, el, dl);
    chk("overrun_valid", overrun_cnt, 8'd2);
    chk("overrun_valid_done", dl, 13);

`ifdef FSTEP_WDOG_EN
    do_frame(1000, 100, 1'b0, 1'b0, 1'b0, el, dl);
    chk("wdog_no_done", dl < 0, 1'b1);
    chk("wdog_step_err", step_err, 1'b1);
`else
    chk("step_err_tied", step_err, 1'b0);
`endif

    // phy_valid in IDLE is ignored.
    {phy_p1_x, phy_p1_y} = {10'd7, 10'd9};
    seen = 1'b0;
    @(negedge clk) phy_valid = 1'b1;
    @(negedge clk) phy_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 if (frame_done) seen = 1'b1;
    end
    chk("idle_valid_done", seen, 1'b0);
    chk("idle_valid_disp", disp(), {10'd500, 10'd20, 10'd260, 10'd176, 10'd480, 10'd0});

    // Scoring: consecutive game_over scores once; saturate to match_over.
    phy_game_over = 1'b1;
    phy_winner = 2'd2;
    do_frame(5, 40, 1'b0, 1'b0, 1'b0, el, dl);
    do_frame(5, 40, 1'b0, 1'b0, 1'b0, el, dl);
    chk("score_once", score_p2, 4'd1);
    for (int n = 2; n <= 14; n++) begin
      phy_game_over = 1'b0;
      do_frame(5, 40, 1'b0, 1'b0, 1'b0, el, dl);
      phy_game_over = 1'b1;
      do_frame(5, 40, 1'b0, 1'b0, 1'b0, el, dl);
    end
    chk("score_14", {score_p2, match_over}, {4'd14, 1'b0});
    phy_game_over = 1'b0;
    do_frame(5, 40, 1'b0, 1'b0, 1'b0, el, dl);
    phy_game_over = 1'b1;
    do_frame(5, 40, 1'b0, 1'b0, 1'b0, el, dl);
    chk("score_15", {score_p1, score_p2, match_over}, {4'd0, 4'd15, 1'b1});
    phy_game_over = 1'b0;

    seen = 1'b0;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 if (en) seen = 1'b1;
    end
    chk("match_over_blocks", seen, 1'b0);
    chk("match_over_no_overrun", overrun_cnt, 8'd2);

    // Reset mid-step.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk) frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1 if (en) seen = 1'b1;
    end
    chk("midstep_rst_no_en", seen, 1'b0);
    chk("midstep_rst_state", {score_p2, match_over, overrun_cnt}, 13'd0);
    chk("midstep_rst_disp", disp(), {10'd50, 10'd176, 10'd260, 10'd176, 10'd260, 10'd120});
    do_frame(5, 40, 1'b0, 1'b0, 1'b0, el, dl);
    chk("post_rst_en_lat", el, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
